// File: rtl/clk_rst_pkg.sv
// Shared clock/reset bring-up types: sequencer state codes and the
// default timing constants used when integrating with clock_gen.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_VIDEO = 3'd2,
        ST_REL_AUDIO = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    // 50 MHz board clock defaults
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_FILTER    = 8;
    localparam int DEF_LOCK_TIMEOUT   = 500000;
    localparam int DEF_STAGE_DELAY    = 256;
    localparam int DEF_MAX_RETRIES    = 3;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer for the two asynchronous PLL lock flags.
// Ports: clk_in, reset (sync, active-high), raw[1:0] in, lk[1:0] out.
module lock_sync (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [1:0] raw,
    output logic [1:0] lk
);

    logic [1:0] meta;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta <= 2'b00;
            lk   <= 2'b00;
        end else begin
            meta <= raw;
            lk   <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// PLL bring-up and ordered per-domain reset release (video, audio, CPU).
// Ports: clk_in, reset, pll_locked_raw[1:0], fault_clear in;
//        pll_rst, rst_video/audio/cpu, sys_ready, fault, retry_count,
//        lock_loss_count, state (debug code) out. All outputs registered.
module reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STAGE_DELAY    = DEF_STAGE_DELAY,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [1:0] pll_locked_raw,
    input  logic       fault_clear,
    output logic       pll_rst,
    output logic       rst_video,
    output logic       rst_audio,
    output logic       rst_cpu,
    output logic       sys_ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    localparam int CNT_MAX = max4(PLL_RST_CYCLES, LOCK_FILTER,
                                  LOCK_TIMEOUT, STAGE_DELAY);
    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam int FW = $clog2(LOCK_FILTER) + 1;

    localparam logic [CW-1:0] PRC_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SD_LAST   = CW'(STAGE_DELAY - 1);
    localparam logic [FW-1:0] FILT_FULL = FW'(LOCK_FILTER);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

    logic [1:0]    lk;
    logic          lk_ok;
    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [1:0]    retry_d;
    logic [7:0]    loss_d;

    lock_sync u_lock_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .raw    (pll_locked_raw),
        .lk     (lk)
    );

    assign lk_ok = &lk;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q         <= ST_PLL_RST;
            cnt_q           <= '0;
            filt_q          <= '0;
            retry_count     <= 2'd0;
            lock_loss_count <= 8'd0;
            pll_rst         <= 1'b1;
            rst_video       <= 1'b1;
            rst_audio       <= 1'b1;
            rst_cpu         <= 1'b1;
            sys_ready       <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            filt_q          <= filt_d;
            retry_count     <= retry_d;
            lock_loss_count <= loss_d;
            // outputs decoded from the next state so they track state_q
            pll_rst   <= (state_d == ST_PLL_RST) ||
                         (state_d == ST_FAULT);
            rst_video <= !((state_d == ST_REL_VIDEO) ||
                           (state_d == ST_REL_AUDIO) ||
                           (state_d == ST_RUN));
            rst_audio <= !((state_d == ST_REL_AUDIO) ||
                           (state_d == ST_RUN));
            rst_cpu   <= (state_d != ST_RUN);
            sys_ready <= (state_d == ST_RUN);
            fault     <= (state_d == ST_FAULT);
        end
    end

    assign state = state_q;

    always_comb begin
        filt_d = filt_q;
        if ((state_q == ST_PLL_RST) || !lk_ok)
            filt_d = '0;
        else if (filt_q != FILT_FULL)
            filt_d = filt_q + 1'b1;

        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_count;
        loss_d  = lock_loss_count;

        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PRC_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // lock is checked first so it wins over a timeout
                if (filt_d == FILT_FULL) begin
                    state_d = ST_REL_VIDEO;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_count == RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_PLL_RST;
                        retry_d = retry_count + 1'b1;
                    end
                end
            end
            ST_REL_VIDEO, ST_REL_AUDIO: begin
                if (!lk_ok) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    if (lock_loss_count != 8'hFF)
                        loss_d = lock_loss_count + 8'd1;
                end else if (cnt_q == SD_LAST) begin
                    cnt_d = '0;
                    if (state_q == ST_REL_VIDEO) begin
                        state_d = ST_REL_AUDIO;
                    end else begin
                        state_d = ST_RUN;
                        retry_d = 2'd0;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                if (!lk_ok) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    if (lock_loss_count != 8'hFF)
                        loss_d = lock_loss_count + 8'd1;
                end
            end
            ST_FAULT: begin
                cnt_d = cnt_q;
                if (fault_clear) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    retry_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
